// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative 64-bit multiply (shift-add) and divide (restoring) with sign handling and divide fast path
module muldiv_unit #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] muldiv_rs1_data_i,
    input  logic [XLEN-1:0] muldiv_rs2_data_i,
    input  logic            muldiv_rs1_sign_i,
    input  logic            muldiv_rs2_sign_i,
    input  logic            muldiv_req_valid_i,
    input  logic            muldiv_mul_en_i,
    input  logic            flush_i,
    output logic [XLEN-1:0] muldiv_data_1_o,
    output logic [XLEN-1:0] muldiv_data_2_o,
    output logic            muldiv_resp_valid_o,
    output logic            muldiv_stall_o
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};
    state_t state, state_n;
    logic [6:0] count;
    logic [XLEN-1:0] hi, lo, m, hi_n, lo_n, a_mag, b_mag, rem_sub;
    logic mul, neg_q, neg_r, a_neg, b_neg, accept, div_zero, ovf, fast, ge;
    logic [XLEN:0] mul_sum, rem_try;
    logic [2*XLEN-1:0] product;
    assign a_neg    = muldiv_rs1_sign_i & muldiv_rs1_data_i[XLEN-1];
    assign b_neg    = muldiv_rs2_sign_i & muldiv_rs2_data_i[XLEN-1];
    assign a_mag    = a_neg ? -muldiv_rs1_data_i : muldiv_rs1_data_i;
    assign b_mag    = b_neg ? -muldiv_rs2_data_i : muldiv_rs2_data_i;
    assign accept   = state == IDLE && muldiv_req_valid_i && !flush_i;
    assign div_zero = !muldiv_mul_en_i && muldiv_rs2_data_i == '0;
    assign ovf      = !muldiv_mul_en_i && muldiv_rs1_sign_i && muldiv_rs2_sign_i &&
                      muldiv_rs1_data_i == MIN && muldiv_rs2_data_i == '1;
    assign fast     = div_zero || ovf;
    // hi holds the running product high half / partial remainder; lo holds multiplier / dividend-quotient
    assign mul_sum  = {1'b0, hi} + (lo[0] ? {1'b0, m} : '0);
    assign rem_try  = {hi, lo[XLEN-1]};
    assign ge       = rem_try >= {1'b0, m};
    assign rem_sub  = rem_try[XLEN-1:0] - m;
    assign hi_n     = mul ? mul_sum[XLEN:1] : (ge ? rem_sub : rem_try[XLEN-1:0]);
    assign lo_n     = mul ? {mul_sum[0], lo[XLEN-1:1]} : {lo[XLEN-2:0], ge};
    assign product  = neg_q ? -{hi_n, lo_n} : {hi_n, lo_n};

    always_ff @(posedge clk) begin
        state <= !rst ? IDLE : state_n;
    end

    always_comb begin
        state_n = flush_i ? IDLE :
                  accept ? (fast ? DONE : BUSY) :
                  state == BUSY ? (count == 7'(XLEN-1) ? DONE : BUSY) : IDLE;
    end

    always_comb begin
        muldiv_resp_valid_o = rst && state == DONE;
        muldiv_stall_o      = rst && ((state == IDLE && muldiv_req_valid_i) || state == BUSY);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            {mul, neg_q, neg_r, count, m, hi, lo} <= '0;
            muldiv_data_1_o <= '0;
            muldiv_data_2_o <= '0;
        end else if (accept) begin
            mul   <= muldiv_mul_en_i;
            neg_q <= a_neg ^ b_neg;
            neg_r <= a_neg;
            m     <= muldiv_mul_en_i ? a_mag : b_mag;
            lo    <= muldiv_mul_en_i ? b_mag : a_mag;
            hi    <= '0;
            count <= '0;
            if (fast) begin
                muldiv_data_1_o <= div_zero ? '1 : MIN;
                muldiv_data_2_o <= div_zero ? muldiv_rs1_data_i : '0;
            end
        end else if (state == BUSY) begin
            hi    <= hi_n;
            lo    <= lo_n;
            count <= count + 7'd1;
            if (state_n == DONE) begin
                muldiv_data_1_o <= mul ? product[XLEN-1:0] : (neg_q ? -lo_n : lo_n);
                muldiv_data_2_o <= mul ? product[2*XLEN-1:XLEN] : (neg_r ? -hi_n : hi_n);
            end
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: scoreboard bench for muldiv_unit with directed corner cases and random operations
module tb_muldiv_unit;
    localparam logic [63:0] MIN = 64'h8000_0000_0000_0000;
    logic clk = 0, rst = 0;
    logic [63:0] rs1 = '0, rs2 = '0;
    logic s1 = 0, s2 = 0, req = 0, mul_en = 0, flush = 0;
    logic [63:0] d1, d2;
    logic resp, stall;
    int cyc = 0, errors = 0, checks = 0;
    logic [63:0] last_d1 = '0, last_d2 = '0;
    typedef struct {logic [63:0] d1, d2; int due;} exp_t;
    exp_t scb[$];
    exp_t e;

    muldiv_unit dut (
        .clk(clk), .rst(rst),
        .muldiv_rs1_data_i(rs1), .muldiv_rs2_data_i(rs2),
        .muldiv_rs1_sign_i(s1), .muldiv_rs2_sign_i(s2),
        .muldiv_req_valid_i(req), .muldiv_mul_en_i(mul_en), .flush_i(flush),
        .muldiv_data_1_o(d1), .muldiv_data_2_o(d2),
        .muldiv_resp_valid_o(resp), .muldiv_stall_o(stall)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (resp) begin
            if (scb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_resp: got resp_valid=1 at cycle %0d expected none", cyc);
            end else begin
                e = scb.pop_front();
                chk("data_1", d1, e.d1);
                chk("data_2", d2, e.d2);
                chk("latency", 64'(cyc), 64'(e.due));
            end
        end
    end

    // Arithmetic reference: full-width signed products and truncating signed division
    function automatic logic [127:0] model(input logic [63:0] a, input logic [63:0] b,
                                           input logic sa, input logic sb, input logic m);
        logic signed [127:0] x, y;
        logic signed [64:0] p, q;
        if (m) begin
            x = {{64{sa & a[63]}}, a};
            y = {{64{sb & b[63]}}, b};
            return x * y;
        end
        if (b == '0) return {a, {64{1'b1}}};
        p = {sa & a[63], a};
        q = {sb & b[63], b};
        return {64'(p % q), 64'(p / q)};
    endfunction

    function automatic logic [63:0] rnd64();
        case ($urandom % 6)
            0: return '0;
            1: return '1;
            2: return MIN;
            3: return 64'($urandom % 16);
            default: return {$urandom, $urandom};
        endcase
    endfunction

    task automatic issue(input logic [63:0] a, input logic [63:0] b, input logic sa, input logic sb,
                         input logic m, input bit hold, input bit push,
                         input logic [63:0] e1, input logic [63:0] e2, input bit fast);
        exp_t x;
        @(negedge clk);
        rs1 = a; rs2 = b; s1 = sa; s2 = sb; mul_en = m; req = 1;
        if (push) begin
            x.d1 = e1; x.d2 = e2; x.due = cyc + 1 + (fast ? 0 : 64);
            scb.push_back(x);
            last_d1 = e1; last_d2 = e2;
        end
        #1 chk("stall_accept", {63'b0, stall}, 64'd1);
        @(negedge clk);
        if (!hold) req = 0;
        rs1 = {$urandom, $urandom}; rs2 = {$urandom, $urandom};
        s1 = 1'($urandom); s2 = 1'($urandom); mul_en = 1'($urandom);
        chk("stall_first", {63'b0, stall}, fast ? 64'd0 : 64'd1);
    endtask

    task automatic wait_done();
        int n = 0;
        while (scb.size() != 0 && n < 300) begin
            @(negedge clk);
            #1 n++;
        end
        if (scb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL timeout: got no resp_valid after %0d cycles expected one", n);
            scb.delete();
        end
    endtask

    task automatic rand_op(input bit hold);
        logic [63:0] a, b;
        logic sa, sb, m;
        logic [127:0] r;
        a = rnd64(); b = rnd64();
        sa = 1'($urandom); sb = 1'($urandom); m = 1'($urandom);
        r = model(a, b, sa, sb, m);
        issue(a, b, sa, sb, m, hold, 1, r[63:0], r[127:64],
              !m && (b == '0 || (sa && sb && a == MIN && b == '1)));
        wait_done();
        if (hold) begin
            chk("stall_done", {63'b0, stall}, 64'd0);
            req = 0;
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        req = 1;
        #1 chk("rst_stall", {63'b0, stall}, 64'd0);
        chk("rst_d1", d1, '0);
        chk("rst_d2", d2, '0);
        chk("rst_resp", {63'b0, resp}, 64'd0);
        req = 0;
        rst = 1;
        issue(64'hFFFF_FFFF_FFFF_FFFD, 64'd5, 1, 1, 1, 0, 1,
              64'hFFFF_FFFF_FFFF_FFF1, 64'hFFFF_FFFF_FFFF_FFFF, 0);
        repeat (30) begin
            @(negedge clk);
            chk("stall_busy", {63'b0, stall}, 64'd1);
        end
        wait_done();
        issue('1, '1, 0, 0, 1, 0, 1, 64'd1, 64'hFFFF_FFFF_FFFF_FFFE, 0);
        wait_done();
        issue(-64'd7, 64'd2, 1, 1, 0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFD, '1, 0);
        wait_done();
        issue(64'd42, 64'd0, 0, 0, 0, 0, 1, '1, 64'd42, 1);
        wait_done();
        issue(MIN, '1, 1, 1, 0, 0, 1, MIN, '0, 1);
        wait_done();
        issue(-64'd100, 64'd7, 1, 0, 0, 0, 1, -64'd14, -64'd2, 0);
        wait_done();
        // Flush at BUSY cycle 10: no response, outputs keep the previous result
        issue(64'd123, 64'd456, 0, 0, 1, 0, 0, '0, '0, 0);
        repeat (9) @(negedge clk);
        flush = 1;
        @(negedge clk);
        flush = 0;
        chk("flush_stall", {63'b0, stall}, 64'd0);
        chk("flush_d1", d1, last_d1);
        chk("flush_d2", d2, last_d2);
        repeat (70) @(negedge clk);
        chk("flush_keep_d1", d1, last_d1);
        rand_op(0);
        // Reset at BUSY cycle 30 discards the operation
        issue(64'd99, 64'd3, 0, 0, 0, 0, 0, '0, '0, 0);
        repeat (29) @(negedge clk);
        rst = 0;
        req = 1;
        @(negedge clk);
        chk("busy_rst_d1", d1, '0);
        chk("busy_rst_d2", d2, '0);
        chk("busy_rst_resp", {63'b0, resp}, 64'd0);
        chk("busy_rst_stall", {63'b0, stall}, 64'd0);
        rst = 1;
        req = 0;
        repeat (70) @(negedge clk);
        issue(64'd1000, 64'd10, 0, 0, 0, 1, 1, 64'd100, 64'd0, 0);
        wait_done();
        chk("hold_done_stall", {63'b0, stall}, 64'd0);
        req = 0;
        for (int i = 0; i < 24; i++) rand_op(i % 4 == 0);
        repeat (5) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter XLEN, default 64: operand and result width; only 64 is supported.
REQ-002 clk  input  1  the single clock; all state updates occur on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-low.
REQ-004 muldiv_rs1_data_i  input  64  operand A (multiplicand or dividend).
REQ-005 muldiv_rs2_data_i  input  64  operand B (multiplier or divisor).
REQ-006 muldiv_rs1_sign_i  input  1  1 = operand A is signed.
REQ-007 muldiv_rs2_sign_i  input  1  1 = operand B is signed.
REQ-008 muldiv_req_valid_i  input  1  request present; held by EX while the instruction waits.
REQ-009 muldiv_mul_en_i  input  1  1 = multiply, 0 = divide/remainder.
REQ-010 flush_i  input  1  abort the operation in flight.
REQ-011 muldiv_data_1_o  output  64  product low half (multiply) or quotient (divide).
REQ-012 muldiv_data_2_o  output  64  product high half (multiply) or remainder (divide).
REQ-013 muldiv_resp_valid_o  output  1  results valid this cycle.
REQ-014 muldiv_stall_o  output  1  pipeline hold request.

Function
REQ-015 The unit SHALL be a three-state FSM: IDLE, BUSY, DONE.
REQ-016 IDLE with req_valid_i=1 and flush_i=0 SHALL accept: latch operands, signs and mul_en, then go to BUSY (or to DONE, per REQ-022).
REQ-017 Operand inputs SHALL be ignored outside the accept edge; only the latched copies are used.
REQ-018 BUSY SHALL last exactly 64 cycles, tracked by a 7-bit counter, and then go to DONE.
- Multiply: radix-2 shift-add, one bit per cycle.
- Divide: restoring, one quotient bit per cycle.
REQ-019 DONE SHALL last one cycle, assert resp_valid_o=1, and return unconditionally to IDLE.
- A req_valid_i still high during DONE SHALL NOT be re-accepted in that cycle.
- The next accept is possible at the earliest in the following IDLE cycle.
REQ-020 stall_o SHALL equal (IDLE and req_valid_i) or BUSY; it is 0 in DONE.
REQ-021 Normal latency: resp_valid_o SHALL be high in the 65th cycle after the accept edge.
REQ-022 The divide fast path SHALL go from IDLE straight to DONE, so resp_valid_o is high in the 1st cycle after the accept edge, in two cases:
- divisor zero;
- both operands signed, A=0x8000_0000_0000_0000 and B=all-ones.
REQ-023 Signed handling: each signed operand with MSB=1 SHALL be converted to its magnitude before iteration.
REQ-024 Multiply result: the 128-bit product SHALL be negated when exactly one operand is negative; data_1 = bits[63:0], data_2 = bits[127:64].
REQ-025 This covers mul/mulh (signed x signed), mulhsu (signed x unsigned) and mulhu (unsigned x unsigned).
REQ-026 Divide result signs:
- quotient negated when exactly one operand is negative;
- remainder takes the sign of the dividend.
REQ-027 Divide by zero SHALL return quotient = all-ones and remainder = operand A unchanged, for both signed and unsigned.
REQ-028 Signed overflow (REQ-022 case) SHALL return quotient = 0x8000_0000_0000_0000 and remainder = 0.
REQ-029 data_1_o/data_2_o SHALL be registered, updated on entry to DONE, and hold their value until the next DONE.
REQ-030 flush_i=1 in any state SHALL force IDLE at the next edge.
- A flushed operation SHALL produce no resp_valid_o and SHALL leave data outputs unchanged.
- flush_i takes priority over accept and over the BUSY-to-DONE transition.

Reset
REQ-031 rst=0 at a clock edge SHALL force IDLE, counter=0, all latched operands=0, data_1_o=0, data_2_o=0, resp_valid_o=0.
REQ-032 While rst=0, stall_o SHALL be 0 regardless of req_valid_i.
REQ-033 Reset during BUSY or DONE SHALL discard the operation; no resp_valid_o follows the release of reset.

Verification
REQ-034 mul, A=0xFFFF_FFFF_FFFF_FFFD (-3), B=5, both signed -> resp_valid_o in cycle 65, data_1=0xFFFF_FFFF_FFFF_FFF1, data_2=0xFFFF_FFFF_FFFF_FFFF, stall_o=1 for cycles 0-64.
REQ-035 mulhu, A=B=0xFFFF_FFFF_FFFF_FFFF, unsigned -> data_1=0x0000_0000_0000_0001, data_2=0xFFFF_FFFF_FFFF_FFFE.
REQ-036 div signed, A=-7, B=2 -> data_1=0xFFFF_FFFF_FFFF_FFFD (-3), data_2=0xFFFF_FFFF_FFFF_FFFF (-1), cycle 65.
REQ-037 divu, A=42, B=0 -> resp_valid_o in cycle 1, data_1=0xFFFF_FFFF_FFFF_FFFF, data_2=42; signed overflow case -> cycle 1, data_1=0x8000_0000_0000_0000, data_2=0.
REQ-038 flush_i=1 at BUSY cycle 10 -> IDLE next cycle, no resp_valid_o, data outputs keep the prior result; a new request issued afterwards completes correctly.
REQ-039 rst=0 at BUSY cycle 30 -> all outputs 0 next cycle; req_valid_i held high through DONE -> exactly one resp_valid_o pulse per accept.
